// File: rtl/gpio_pin_ctrl.sv
// gpio_pin_ctrl: pad-side GPIO stage.
//   Registers the output data/enable toward the pads, synchronises the pad
//   inputs (optionally debounced), detects pin edges into per-pin pending bits
//   gated by the interrupt mask, and raises a single registered irq.
// Optional feature: define GPIO_DEBOUNCE_EN to build per-pin debounce counters.
//   Without it the pin state is the synchroniser output directly.

module gpio_pin_ctrl #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pad_in,
  input  logic [WIDTH-1:0] rf_gpio_datareg,
  input  logic [WIDTH-1:0] rf_gpio_tristate,
  input  logic [WIDTH-1:0] rf_gpio_interrupt_mask,
  input  logic [WIDTH-1:0] irq_clear,
  output logic [WIDTH-1:0] ro_gpio_pinstate,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic [WIDTH-1:0] irq_pending,
  output logic             irq
);

  logic [WIDTH-1:0] pad_out_q;
  logic [WIDTH-1:0] pad_oe_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] pinstate;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] pin_edge;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] pending_d;
  logic             irq_q;

  // Output path: tristate=1 means the driver is off, so enable is its inverse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pad_out_q <= '0;
      pad_oe_q  <= '0;
    end else begin
      pad_out_q <= rf_gpio_datareg;
      pad_oe_q  <= ~rf_gpio_tristate;
    end
  end

  // Multi-flop synchroniser for the asynchronous pad inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= pad_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [WIDTH-1:0] pinstate_q;

  // Debounce: a pin only updates after the synchronised value has differed
  // from the current state for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pinstate_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_out[i] == pinstate_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          pinstate_q[i] <= sync_out[i];
          cnt_q[i]      <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign pinstate = pinstate_q;
`else
  assign pinstate = sync_out;
`endif

  // Both rising and falling transitions count as an edge.
  assign pin_edge = pinstate ^ prev_q;

  // Pending next state: a new unmasked edge wins over a simultaneous clear;
  // masked edges are dropped rather than deferred.
  always_comb begin
    pending_d = (pending_q & ~irq_clear) | (pin_edge & rf_gpio_interrupt_mask);
  end

  // Edge history, pending bits and the interrupt request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      prev_q    <= pinstate;
      pending_q <= pending_d;
      irq_q     <= |(pending_q & rf_gpio_interrupt_mask);
    end
  end

  assign ro_gpio_pinstate = pinstate;
  assign pad_out          = pad_out_q;
  assign pad_oe           = pad_oe_q;
  assign irq_pending      = pending_q;
  assign irq              = irq_q;

endmodule

// File: tb/tb_gpio_pin_ctrl.sv
// tb_gpio_pin_ctrl: directed bench for gpio_pin_ctrl (WIDTH=16, SYNC_STAGES=2).
// Debounce checks are built when GPIO_DEBOUNCE_EN is defined for both files.

module tb_gpio_pin_ctrl;

  localparam int unsigned Width = 16;
  localparam int unsigned Sync  = 2;
  localparam int unsigned Deb   = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned Lat = Sync + Deb;
`else
  localparam int unsigned Lat = Sync;
`endif

  logic             clk;
  logic             reset_n;
  logic [Width-1:0] pad_in;
  logic [Width-1:0] rf_gpio_datareg;
  logic [Width-1:0] rf_gpio_tristate;
  logic [Width-1:0] rf_gpio_interrupt_mask;
  logic [Width-1:0] irq_clear;
  logic [Width-1:0] ro_gpio_pinstate;
  logic [Width-1:0] pad_out;
  logic [Width-1:0] pad_oe;
  logic [Width-1:0] irq_pending;
  logic             irq;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_pin_ctrl #(
    .WIDTH          (Width),
    .SYNC_STAGES    (Sync),
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .pad_in                (pad_in),
    .rf_gpio_datareg       (rf_gpio_datareg),
    .rf_gpio_tristate      (rf_gpio_tristate),
    .rf_gpio_interrupt_mask(rf_gpio_interrupt_mask),
    .irq_clear             (irq_clear),
    .ro_gpio_pinstate      (ro_gpio_pinstate),
    .pad_out               (pad_out),
    .pad_oe                (pad_oe),
    .irq_pending           (irq_pending),
    .irq                   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are stable 1 time unit later.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n                = 1'b0;
    pad_in                 = 16'hFFFF;
    rf_gpio_datareg        = 16'h0000;
    rf_gpio_tristate       = 16'hFFFF;
    rf_gpio_interrupt_mask = 16'h0000;
    irq_clear              = 16'h0000;

    // 1: reset state, then pinstate rises with mask=0 and no pending.
    #3;
    check("rst_pinstate", ro_gpio_pinstate, 16'h0000);
    check("rst_pad_out", pad_out, 16'h0000);
    check("rst_pad_oe", pad_oe, 16'h0000);
    check("rst_pending", irq_pending, 16'h0000);
    check("rst_irq", {15'b0, irq}, 16'h0000);
    #9 reset_n = 1'b1;
    tick(Lat - 1);
    check("pin_pre_rise", ro_gpio_pinstate, 16'h0000);
    tick(1);
    check("pin_rise", ro_gpio_pinstate, 16'hFFFF);
    tick(3);
    check("rise_pending", irq_pending, 16'h0000);
    check("rise_irq", {15'b0, irq}, 16'h0000);

    // 2: unmasked edge on pin 3, latency and clear.
    pad_in = 16'hFFF7;
    tick(Lat + 2);
    rf_gpio_interrupt_mask = 16'h0008;
    tick(1);
    check("p3_low_pending", irq_pending, 16'h0000);
    pad_in = 16'hFFFF;
    tick(Lat - 1);
    check("p3_pin_pre", ro_gpio_pinstate, 16'hFFF7);
    tick(1);
    check("p3_pin", ro_gpio_pinstate, 16'hFFFF);
    check("p3_pend_pre", irq_pending, 16'h0000);
    tick(1);
    check("p3_pending", irq_pending, 16'h0008);
    check("p3_irq_pre", {15'b0, irq}, 16'h0000);
    tick(1);
    check("p3_irq", {15'b0, irq}, 16'h0001);
    irq_clear = 16'h0008;
    tick(1);
    irq_clear = 16'h0000;
    check("p3_cleared", irq_pending, 16'h0000);
    check("p3_irq_hold", {15'b0, irq}, 16'h0001);
    tick(1);
    check("p3_irq_drop", {15'b0, irq}, 16'h0000);

    // 3: masked pin 7 edges are discarded, not deferred.
    rf_gpio_interrupt_mask = 16'h0000;
    pad_in = 16'hFF7F;
    tick(Lat);
    check("p7_pin_low", ro_gpio_pinstate, 16'hFF7F);
    tick(2);
    check("p7_pend_a", irq_pending, 16'h0000);
    pad_in = 16'hFFFF;
    tick(Lat);
    check("p7_pin_high", ro_gpio_pinstate, 16'hFFFF);
    tick(2);
    check("p7_pend_b", irq_pending, 16'h0000);
    rf_gpio_interrupt_mask = 16'h0080;
    tick(2);
    check("p7_unmask_pend", irq_pending, 16'h0000);
    check("p7_unmask_irq", {15'b0, irq}, 16'h0000);

    // 4: set wins over simultaneous clear; masking drops irq but keeps pending.
    rf_gpio_interrupt_mask = 16'h0004;
    pad_in = 16'hFFFB;
    tick(Lat + 1);
    check("p2_pending", irq_pending, 16'h0004);
    tick(1);
    check("p2_irq", {15'b0, irq}, 16'h0001);
    pad_in = 16'hFFFF;
    tick(Lat);
    irq_clear = 16'h0004;
    tick(1);
    irq_clear = 16'h0000;
    check("p2_set_wins", irq_pending, 16'h0004);
    check("p2_irq_stays", {15'b0, irq}, 16'h0001);
    rf_gpio_interrupt_mask = 16'h0000;
    tick(1);
    check("p2_mask_irq", {15'b0, irq}, 16'h0000);
    check("p2_mask_keep", irq_pending, 16'h0004);
    rf_gpio_interrupt_mask = 16'h0004;
    tick(1);
    check("p2_unmask_irq", {15'b0, irq}, 16'h0001);
    irq_clear = 16'h0004;
    tick(1);
    irq_clear = 16'h0000;
    check("p2_clear", irq_pending, 16'h0000);
    rf_gpio_interrupt_mask = 16'h0000;

    // 5: pulse filtering on pin 0.
    pad_in = 16'hFFFE;
    tick(Lat + 2);
    check("p0_low", ro_gpio_pinstate, 16'hFFFE);
`ifdef GPIO_DEBOUNCE_EN
    pad_in = 16'hFFFF;
    tick(3);
    pad_in = 16'hFFFE;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("deb_glitch", ro_gpio_pinstate, 16'hFFFE);
    end
    pad_in = 16'hFFFF;
    tick(5);
    check("deb_pre", ro_gpio_pinstate, 16'hFFFE);
    tick(1);
    check("deb_rise", ro_gpio_pinstate, 16'hFFFF);
`else
    pad_in = 16'hFFFF;
    tick(1);
    pad_in = 16'hFFFE;
    tick(1);
    check("nodeb_pulse_hi", ro_gpio_pinstate, 16'hFFFF);
    tick(1);
    check("nodeb_pulse_lo", ro_gpio_pinstate, 16'hFFFE);
`endif

    // 6: registered output path, then asynchronous reset.
    rf_gpio_tristate = 16'hFF00;
    rf_gpio_datareg  = 16'h00A5;
    check("oe_latency", pad_oe, 16'h0000);
    tick(1);
    check("oe_drive", pad_oe, 16'h00FF);
    check("out_data", pad_out, 16'h00A5);
    #2 reset_n = 1'b0;
    #1;
    check("async_oe", pad_oe, 16'h0000);
    check("async_out", pad_out, 16'h0000);
    check("async_pin", ro_gpio_pinstate, 16'h0000);
    check("async_irq", {15'b0, irq}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
